// File: rtl/osf_filter_pkg.sv
// -----------------------------------------------------------------------------
// osf_filter_pkg
// Shared constants and helpers for the per-channel oversampling averager.
//   - Sizing of the sample path, channel memories and config bus.
//   - Endpoint-map addresses of the averager's config registers. These sit in
//     the same write address space as the PID filter's pid_* registers.
//   - Small helpers: ratio saturation and the "last sample of window" count.
// -----------------------------------------------------------------------------
package osf_filter_pkg;

  localparam int N_CHAN    = 8;   // time-multiplexed channels
  localparam int W_CHAN    = 5;   // channel index width on the sample bus
  localparam int W_DIN     = 18;  // signed sample width (in and out)
  localparam int W_OSF     = 4;   // ratio field width
  localparam int MAX_OSF   = 8;   // largest log2 oversample ratio
  localparam int W_WR_ADDR = 16;
  localparam int W_WR_CHAN = 16;
  localparam int W_WR_DATA = 48;

  // 2^MAX_OSF full-scale samples always fit, so the accumulator never wraps.
  localparam int W_SUM = W_DIN + MAX_OSF;
  localparam int W_IDX = $clog2(N_CHAN);

  // Endpoint map: averager config registers.
  localparam logic [W_WR_ADDR-1:0] osf_ratio_addr   = 16'h0010;
  localparam logic [W_WR_ADDR-1:0] osf_clr_req_addr = 16'h0011;

  localparam logic [W_OSF-1:0] MAX_OSF_V = W_OSF'(MAX_OSF);

  // Requested ratios above MAX_OSF are clamped rather than rejected.
  function automatic logic [W_OSF-1:0] sat_ratio(input logic [W_OSF-1:0] r);
    return (r > MAX_OSF_V) ? MAX_OSF_V : r;
  endfunction

  // Count value held by a channel just before its window completes: 2^osf-1.
  function automatic logic [MAX_OSF-1:0] window_last(input logic [W_OSF-1:0] osf);
    logic [MAX_OSF:0] one;
    one = {{MAX_OSF{1'b0}}, 1'b1};
    return MAX_OSF'((one << osf) - one);
  endfunction

endpackage

// File: rtl/osf_filter.sv
// -----------------------------------------------------------------------------
// osf_filter
// Per-channel oversampling averager feeding the PID stage. Accumulates 2^ratio
// time-multiplexed samples per channel and emits their floor average.
//
// Ports:
//   clk_in    in   system clock
//   rst_in    in   asynchronous active-high reset
//   dv_in     in   input sample valid
//   chan_in   in   input sample channel  [W_CHAN]
//   data_in   in   signed input sample   [W_DIN]
//   wr_en     in   config write strobe
//   wr_addr   in   config address        [W_WR_ADDR]
//   wr_chan   in   config target channel [W_WR_CHAN]
//   wr_data   in   config data           [W_WR_DATA]
//   dv_out    out  averaged sample valid (single-cycle pulse)
//   chan_out  out  averaged sample channel (holds between pulses)
//   data_out  out  signed averaged sample  (holds between pulses)
//
// Pipeline: P1 registers the sample plus the channel's sum/count/ratio; P2
// adds, decides window completion, writes back and registers the output.
// A P2 writeback to the channel being fetched is forwarded into P1 so that
// back-to-back samples of one channel are neither lost nor double-counted.
// -----------------------------------------------------------------------------
module osf_filter
  import osf_filter_pkg::*;
(
  input  logic                        clk_in,
  input  logic                        rst_in,
  input  logic                        dv_in,
  input  logic [W_CHAN-1:0]           chan_in,
  input  logic signed [W_DIN-1:0]     data_in,
  input  logic                        wr_en,
  input  logic [W_WR_ADDR-1:0]        wr_addr,
  input  logic [W_WR_CHAN-1:0]        wr_chan,
  input  logic [W_WR_DATA-1:0]        wr_data,
  output logic                        dv_out,
  output logic [W_CHAN-1:0]           chan_out,
  output logic signed [W_DIN-1:0]     data_out
);

  localparam logic [W_CHAN-1:0] N_CHAN_C = W_CHAN'(N_CHAN);

  // Read views of the per-channel state (storage lives in g_chan below).
  logic signed [W_SUM-1:0] sum_mem [N_CHAN];
  logic [MAX_OSF-1:0]      cnt_mem [N_CHAN];
  logic [W_OSF-1:0]        osf_mem [N_CHAN];
  logic [N_CHAN-1:0]       clr_req;

  // P1 registers
  logic                    p1_vld_q,  p1_vld_d;
  logic [W_CHAN-1:0]       p1_chan_q, p1_chan_d;
  logic signed [W_DIN-1:0] p1_data_q, p1_data_d;
  logic signed [W_SUM-1:0] p1_sum_q,  p1_sum_d;
  logic [MAX_OSF-1:0]      p1_cnt_q,  p1_cnt_d;
  logic [W_OSF-1:0]        p1_osf_q,  p1_osf_d;

  // Output registers
  logic                    out_dv_q,   out_dv_d;
  logic [W_CHAN-1:0]       out_chan_q, out_chan_d;
  logic signed [W_DIN-1:0] out_data_q, out_data_d;

  logic [W_IDX-1:0]        in_idx, p1_idx;
  logic                    in_ok;
  logic signed [W_SUM-1:0] new_sum, wb_sum;
  logic [MAX_OSF-1:0]      wb_cnt;
  logic                    win_done, wb_en, fwd;

  // Only the low ratio bits and the clear bit of wr_data carry meaning.
  logic unused_wr_data;
  assign unused_wr_data = ^wr_data[W_WR_DATA-1:W_OSF];

  assign in_idx = chan_in[W_IDX-1:0];
  assign p1_idx = p1_chan_q[W_IDX-1:0];
  assign in_ok  = dv_in && (chan_in < N_CHAN_C);

  // ---------------------------------------------------------------------------
  // P2: accumulate and decide. A pending clear on the P1 entry's channel
  // squashes it: no writeback (the clear zeroes state) and no output.
  // ---------------------------------------------------------------------------
  always_comb begin
    new_sum  = p1_sum_q + {{MAX_OSF{p1_data_q[W_DIN-1]}}, p1_data_q};
    win_done = (p1_cnt_q == window_last(p1_osf_q));
    wb_en    = p1_vld_q && !clr_req[p1_idx];
    wb_sum   = win_done ? '0 : new_sum;
    wb_cnt   = win_done ? '0 : p1_cnt_q + 1'b1;
  end

  always_comb begin
    out_dv_d   = wb_en && win_done;
    out_chan_d = out_chan_q;
    out_data_d = out_data_q;
    if (out_dv_d) begin
      out_chan_d = p1_chan_q;
      // Arithmetic shift gives the floor average; the result always fits W_DIN.
      out_data_d = W_DIN'(new_sum >>> p1_osf_q);
    end
  end

  // ---------------------------------------------------------------------------
  // P1: fetch channel state. The memory write for the previous sample lands on
  // the same edge, so take the P2 result directly when the channels match.
  // A sample arriving while its channel is being cleared is dropped.
  // ---------------------------------------------------------------------------
  always_comb begin
    fwd       = wb_en && (p1_chan_q == chan_in);
    p1_vld_d  = in_ok && !clr_req[in_idx];
    p1_chan_d = chan_in;
    p1_data_d = data_in;
    p1_sum_d  = fwd ? wb_sum : sum_mem[in_idx];
    p1_cnt_d  = fwd ? wb_cnt : cnt_mem[in_idx];
    p1_osf_d  = osf_mem[in_idx];
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      p1_vld_q   <= 1'b0;
      p1_chan_q  <= '0;
      p1_data_q  <= '0;
      p1_sum_q   <= '0;
      p1_cnt_q   <= '0;
      p1_osf_q   <= '0;
      out_dv_q   <= 1'b0;
      out_chan_q <= '0;
      out_data_q <= '0;
    end else begin
      p1_vld_q   <= p1_vld_d;
      p1_chan_q  <= p1_chan_d;
      p1_data_q  <= p1_data_d;
      p1_sum_q   <= p1_sum_d;
      p1_cnt_q   <= p1_cnt_d;
      p1_osf_q   <= p1_osf_d;
      out_dv_q   <= out_dv_d;
      out_chan_q <= out_chan_d;
      out_data_q <= out_data_d;
    end
  end

  assign dv_out   = out_dv_q;
  assign chan_out = out_chan_q;
  assign data_out = out_data_q;

  // ---------------------------------------------------------------------------
  // Per-channel state. A ratio write also raises the clear request so the
  // partial window gathered under the old ratio is discarded on the next edge.
  // ---------------------------------------------------------------------------
  for (genvar gi = 0; gi < N_CHAN; gi++) begin : g_chan
    logic signed [W_SUM-1:0] sum_q;
    logic [MAX_OSF-1:0]      cnt_q;
    logic [W_OSF-1:0]        osf_q;
    logic                    clr_q;
    logic                    wr_hit, ratio_wr, clr_wr, wb_hit;

    assign wr_hit   = wr_en && (wr_chan == W_WR_CHAN'(gi));
    assign ratio_wr = wr_hit && (wr_addr == osf_ratio_addr);
    assign clr_wr   = wr_hit && (wr_addr == osf_clr_req_addr) && wr_data[0];
    assign wb_hit   = wb_en && (p1_idx == W_IDX'(gi));

    always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
        sum_q <= '0;
        cnt_q <= '0;
        osf_q <= '0;
        clr_q <= 1'b0;
      end else begin
        if (clr_q) begin
          sum_q <= '0;
          cnt_q <= '0;
        end else if (wb_hit) begin
          sum_q <= wb_sum;
          cnt_q <= wb_cnt;
        end
        if (ratio_wr) begin
          osf_q <= sat_ratio(wr_data[W_OSF-1:0]);
        end
        // A fresh request wins over retiring the current one.
        if (ratio_wr || clr_wr) begin
          clr_q <= 1'b1;
        end else if (clr_q) begin
          clr_q <= 1'b0;
        end
      end
    end

    assign sum_mem[gi] = sum_q;
    assign cnt_mem[gi] = cnt_q;
    assign osf_mem[gi] = osf_q;
    assign clr_req[gi] = clr_q;
  end

endmodule

// File: tb/tb_osf_filter.sv
// -----------------------------------------------------------------------------
// tb_osf_filter
// Self-checking bench for osf_filter. The reference model keeps, per channel,
// the running arithmetic sum and sample count of the open window plus the
// ratio, and applies these rules each cycle:
//   - a valid sample joins its channel's window unless a clear/ratio write for
//     that channel happens in the same or the previous cycle;
//   - when a window holds 2^ratio samples, floor(sum / 2^ratio) is due on the
//     outputs two cycles after the completing sample's cycle;
//   - a clear or ratio write empties the channel's window.
// Each output is printed as one line; chan_out/data_out must hold between
// pulses.
// -----------------------------------------------------------------------------
module tb_osf_filter;
  import osf_filter_pkg::*;

  logic                     clk_in = 1'b0;
  logic                     rst_in;
  logic                     dv_in;
  logic [W_CHAN-1:0]        chan_in;
  logic signed [W_DIN-1:0]  data_in;
  logic                     wr_en;
  logic [W_WR_ADDR-1:0]     wr_addr;
  logic [W_WR_CHAN-1:0]     wr_chan;
  logic [W_WR_DATA-1:0]     wr_data;
  logic                     dv_out;
  logic [W_CHAN-1:0]        chan_out;
  logic signed [W_DIN-1:0]  data_out;

  osf_filter dut (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .dv_in    (dv_in),
    .chan_in  (chan_in),
    .data_in  (data_in),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_chan  (wr_chan),
    .wr_data  (wr_data),
    .dv_out   (dv_out),
    .chan_out (chan_out),
    .data_out (data_out)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    int cyc;
    int chan;
    int val;
  } exp_t;

  // Reference model state
  longint m_sum   [N_CHAN];
  int     m_cnt   [N_CHAN];
  int     m_ratio [N_CHAN];
  bit     clr_prev[N_CHAN];
  exp_t   exp_q[$];

  int                      cyc;
  bit                      exp_dv;
  logic [W_CHAN-1:0]       hold_c;
  logic signed [W_DIN-1:0] hold_d;

  int obs_pulses, obs_first_c, obs_first_d, obs_last_c, obs_last_d;
  int checks, errors;

  function automatic int floor_div(input longint s, input int r);
    longint d, q;
    d = longint'(1) << r;
    q = s / d;
    if (q * d > s) q = q - 1;
    return int'(q);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N_CHAN; i++) begin
      m_sum[i]    = 0;
      m_cnt[i]    = 0;
      m_ratio[i]  = 0;
      clr_prev[i] = 1'b0;
    end
    exp_q.delete();
    exp_dv = 1'b0;
    hold_c = '0;
    hold_d = '0;
  endtask

  // Drives one cycle of stimulus, advances the model, steps the clock and
  // leaves exp_dv/hold_c/hold_d describing the outputs now visible.
  task automatic cycle(input bit dv, input int ch, input int d,
                       input bit we, input logic [W_WR_ADDR-1:0] addr,
                       input int wch, input logic [W_WR_DATA-1:0] wd);
    bit   clr_now [N_CHAN];
    bit   hit;
    int   cur;
    exp_t e;
    cur = cyc;
    for (int i = 0; i < N_CHAN; i++) clr_now[i] = 1'b0;
    hit = we && (wch >= 0) && (wch < N_CHAN);
    if (hit && ((addr == osf_ratio_addr) || (addr == osf_clr_req_addr && wd[0])))
      clr_now[wch] = 1'b1;
    if (dv && ch < N_CHAN && !clr_now[ch] && !clr_prev[ch]) begin
      m_sum[ch] += d;
      m_cnt[ch]++;
      if (m_cnt[ch] == (1 << m_ratio[ch])) begin
        e.cyc  = cur;
        e.chan = ch;
        e.val  = floor_div(m_sum[ch], m_ratio[ch]);
        exp_q.push_back(e);
        m_sum[ch] = 0;
        m_cnt[ch] = 0;
      end
    end
    if (hit && addr == osf_ratio_addr)
      m_ratio[wch] = (int'(wd[3:0]) > MAX_OSF) ? MAX_OSF : int'(wd[3:0]);
    for (int i = 0; i < N_CHAN; i++) begin
      if (clr_now[i]) begin
        m_sum[i] = 0;
        m_cnt[i] = 0;
      end
      clr_prev[i] = clr_now[i];
    end

    dv_in   = dv;
    chan_in = W_CHAN'(ch);
    data_in = W_DIN'(d);
    wr_en   = we;
    wr_addr = addr;
    wr_chan = W_WR_CHAN'(wch);
    wr_data = wd;
    @(posedge clk_in);
    @(negedge clk_in);

    exp_dv = 1'b0;
    if (exp_q.size() > 0 && exp_q[0].cyc == cur - 1) begin
      exp_dv = 1'b1;
      hold_c = W_CHAN'(exp_q[0].chan);
      hold_d = W_DIN'(exp_q[0].val);
      void'(exp_q.pop_front());
    end
    if (dv_out === 1'b1) begin
      obs_pulses++;
      obs_last_c = int'(chan_out);
      obs_last_d = int'(data_out);
      if (obs_pulses == 1) begin
        obs_first_c = obs_last_c;
        obs_first_d = obs_last_d;
      end
      $display("out cyc=%0d chan=%0d data=%0d", cur, chan_out, data_out);
    end
    cyc = cur + 1;
  endtask

  task automatic idle();
    cycle(1'b0, 0, 0, 1'b0, '0, 0, '0);
  endtask

  task automatic wr_ratio(input int ch, input int r);
    cycle(1'b0, 0, 0, 1'b1, osf_ratio_addr, ch, W_WR_DATA'(r));
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst_in = 1'b1;
    dv_in = 1'b0; chan_in = '0; data_in = '0;
    wr_en = 1'b0; wr_addr = '0; wr_chan = '0; wr_data = '0;
    repeat (2) @(negedge clk_in);
    checks++;
    if (dv_out !== 1'b0 || chan_out !== '0 || data_out !== '0) begin
      errors++;
      $display("FAIL reset dv_out=%0b chan_out=%0d data_out=%0d (required 0 0 0)",
               dv_out, chan_out, data_out);
    end
    rst_in = 1'b0;
    model_reset();
    cyc = 0;
    for (int s = 0; s < 2; s++) begin
      idle();
      checks++;
      if (dv_out !== exp_dv || chan_out !== hold_c || data_out !== hold_d) begin
        errors++;
        $display("FAIL reset_idle cyc=%0d dv_out=%0b/%0b chan_out=%0d/%0d data_out=%0d/%0d (got/exp)",
                 cyc, dv_out, exp_dv, chan_out, hold_c, data_out, hold_d);
      end
    end
  endtask

  task automatic test_ratio2();
    int smp [4] = '{100, 102, 98, 104};
    obs_pulses = 0;
    for (int s = 0; s < 9; s++) begin
      if (s == 0) wr_ratio(3, 2);
      else if (s >= 2 && s <= 5) cycle(1'b1, 3, smp[s-2], 1'b0, '0, 0, '0);
      else idle();
      checks++;
      if (dv_out !== exp_dv || chan_out !== hold_c || data_out !== hold_d) begin
        errors++;
        $display("FAIL ratio2 cyc=%0d dv_out=%0b/%0b chan_out=%0d/%0d data_out=%0d/%0d (got/exp)",
                 cyc, dv_out, exp_dv, chan_out, hold_c, data_out, hold_d);
      end
    end
    checks++;
    if (obs_pulses != 1 || obs_last_c != 3 || obs_last_d != 101) begin
      errors++;
      $display("FAIL ratio2_result pulses=%0d chan=%0d data=%0d (required 1 3 101)",
               obs_pulses, obs_last_c, obs_last_d);
    end
  endtask

  task automatic test_floor_passthrough();
    obs_pulses = 0;
    for (int s = 0; s < 9; s++) begin
      case (s)
        0: wr_ratio(0, 1);
        1: wr_ratio(1, 0);
        3: cycle(1'b1, 0, -3, 1'b0, '0, 0, '0);
        4: cycle(1'b1, 0, -4, 1'b0, '0, 0, '0);
        5: cycle(1'b1, 1, -131072, 1'b0, '0, 0, '0);
        default: idle();
      endcase
      checks++;
      if (dv_out !== exp_dv || chan_out !== hold_c || data_out !== hold_d) begin
        errors++;
        $display("FAIL floor_pass cyc=%0d dv_out=%0b/%0b chan_out=%0d/%0d data_out=%0d/%0d (got/exp)",
                 cyc, dv_out, exp_dv, chan_out, hold_c, data_out, hold_d);
      end
    end
    checks++;
    if (obs_pulses != 2 || obs_first_c != 0 || obs_first_d != -4 ||
        obs_last_c != 1 || obs_last_d != -131072) begin
      errors++;
      $display("FAIL floor_pass_result pulses=%0d first=%0d:%0d last=%0d:%0d (required 2 0:-4 1:-131072)",
               obs_pulses, obs_first_c, obs_first_d, obs_last_c, obs_last_d);
    end
  endtask

  task automatic test_back_to_back();
    int smp [8] = '{10, 20, 11, 21, 12, 22, 13, 23};
    obs_pulses = 0;
    for (int s = 0; s < 18; s++) begin
      if (s == 0) wr_ratio(2, 2);
      else if (s == 1) wr_ratio(5, 2);
      else if (s >= 3 && s <= 10) cycle(1'b1, (s % 2 == 1) ? 2 : 5, smp[s-3], 1'b0, '0, 0, '0);
      else if (s >= 11 && s <= 14) cycle(1'b1, 2, 7, 1'b0, '0, 0, '0);
      else idle();
      checks++;
      if (dv_out !== exp_dv || chan_out !== hold_c || data_out !== hold_d) begin
        errors++;
        $display("FAIL back_to_back cyc=%0d dv_out=%0b/%0b chan_out=%0d/%0d data_out=%0d/%0d (got/exp)",
                 cyc, dv_out, exp_dv, chan_out, hold_c, data_out, hold_d);
      end
    end
    checks++;
    if (obs_pulses != 3 || obs_first_c != 2 || obs_first_d != 11 ||
        obs_last_c != 2 || obs_last_d != 7) begin
      errors++;
      $display("FAIL back_to_back_result pulses=%0d first=%0d:%0d last=%0d:%0d (required 3 2:11 2:7)",
               obs_pulses, obs_first_c, obs_first_d, obs_last_c, obs_last_d);
    end
  endtask

  task automatic test_full_scale();
    obs_pulses = 0;
    for (int s = 0; s < 519; s++) begin
      // A requested ratio of 15 saturates to the 256-sample window.
      if (s == 0) wr_ratio(4, 15);
      else if (s >= 2 && s <= 257) cycle(1'b1, 4, 131071, 1'b0, '0, 0, '0);
      else if (s >= 260 && s <= 515) cycle(1'b1, 4, -131072, 1'b0, '0, 0, '0);
      else idle();
      checks++;
      if (dv_out !== exp_dv || chan_out !== hold_c || data_out !== hold_d) begin
        errors++;
        $display("FAIL full_scale cyc=%0d dv_out=%0b/%0b chan_out=%0d/%0d data_out=%0d/%0d (got/exp)",
                 cyc, dv_out, exp_dv, chan_out, hold_c, data_out, hold_d);
      end
    end
    checks++;
    if (obs_pulses != 2 || obs_first_d != 131071 || obs_last_c != 4 || obs_last_d != -131072) begin
      errors++;
      $display("FAIL full_scale_result pulses=%0d first=%0d last=%0d:%0d (required 2 131071 4:-131072)",
               obs_pulses, obs_first_d, obs_last_c, obs_last_d);
    end
  endtask

  task automatic test_clear();
    obs_pulses = 0;
    for (int s = 0; s < 26; s++) begin
      case (s)
        0: wr_ratio(6, 2);
        2, 3: cycle(1'b1, 6, 50, 1'b0, '0, 0, '0);
        4: cycle(1'b0, 0, 0, 1'b1, osf_clr_req_addr, 6, 48'd1);
        6, 7, 8, 9: cycle(1'b1, 6, 8, 1'b0, '0, 0, '0);
        13, 14, 15: cycle(1'b1, 6, 30, 1'b0, '0, 0, '0);
        // Completing sample and clear request in the same cycle: squashed.
        16: cycle(1'b1, 6, 30, 1'b1, osf_clr_req_addr, 6, 48'd1);
        18, 19, 20, 21: cycle(1'b1, 6, 9, 1'b0, '0, 0, '0);
        default: idle();
      endcase
      checks++;
      if (dv_out !== exp_dv || chan_out !== hold_c || data_out !== hold_d) begin
        errors++;
        $display("FAIL clear cyc=%0d dv_out=%0b/%0b chan_out=%0d/%0d data_out=%0d/%0d (got/exp)",
                 cyc, dv_out, exp_dv, chan_out, hold_c, data_out, hold_d);
      end
    end
    checks++;
    if (obs_pulses != 2 || obs_first_d != 8 || obs_last_c != 6 || obs_last_d != 9) begin
      errors++;
      $display("FAIL clear_result pulses=%0d first=%0d last=%0d:%0d (required 2 8 6:9)",
               obs_pulses, obs_first_d, obs_last_c, obs_last_d);
    end
  endtask

  task automatic test_async_reset();
    for (int s = 0; s < 7; s++) begin
      case (s)
        0: wr_ratio(2, 2);
        1: wr_ratio(7, 0);
        3: cycle(1'b1, 2, 40, 1'b0, '0, 0, '0);
        4: cycle(1'b1, 2, 41, 1'b0, '0, 0, '0);
        5: cycle(1'b1, 7, 1234, 1'b0, '0, 0, '0);
        default: idle();
      endcase
      checks++;
      if (dv_out !== exp_dv || chan_out !== hold_c || data_out !== hold_d) begin
        errors++;
        $display("FAIL async_reset_pre cyc=%0d dv_out=%0b/%0b chan_out=%0d/%0d data_out=%0d/%0d (got/exp)",
                 cyc, dv_out, exp_dv, chan_out, hold_c, data_out, hold_d);
      end
    end
    // The ch7 pass-through pulse is on the outputs now; reset between edges.
    #2 rst_in = 1'b1;
    #1;
    checks++;
    if (dv_out !== 1'b0 || chan_out !== '0 || data_out !== '0) begin
      errors++;
      $display("FAIL async_reset dv_out=%0b chan_out=%0d data_out=%0d (required 0 0 0)",
               dv_out, chan_out, data_out);
    end
    model_reset();
    @(posedge clk_in);
    @(negedge clk_in);
    rst_in = 1'b0;
    obs_pulses = 0;
    for (int s = 0; s < 3; s++) begin
      if (s == 0) cycle(1'b1, 2, 555, 1'b0, '0, 0, '0);
      else idle();
      checks++;
      if (dv_out !== exp_dv || chan_out !== hold_c || data_out !== hold_d) begin
        errors++;
        $display("FAIL async_reset_post cyc=%0d dv_out=%0b/%0b chan_out=%0d/%0d data_out=%0d/%0d (got/exp)",
                 cyc, dv_out, exp_dv, chan_out, hold_c, data_out, hold_d);
      end
    end
    checks++;
    if (obs_pulses != 1 || obs_last_c != 2 || obs_last_d != 555) begin
      errors++;
      $display("FAIL async_reset_result pulses=%0d chan=%0d data=%0d (required 1 2 555)",
               obs_pulses, obs_last_c, obs_last_d);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 1203; n++) begin
      bit                   dv, we;
      int                   ch, d, wch, sel;
      logic [W_WR_ADDR-1:0] addr;
      logic [W_WR_DATA-1:0] wd;
      dv   = ($urandom_range(0, 3) != 0) && (n < 1200);
      ch   = int'($urandom_range(0, 7));
      d    = int'($urandom_range(0, 262143)) - 131072;
      we   = ($urandom_range(0, 15) == 0) && (n < 1200);
      wch  = int'($urandom_range(0, 7));
      addr = osf_ratio_addr;
      wd   = '0;
      if (we) begin
        sel = int'($urandom_range(0, 9));
        if (sel < 5) wd = W_WR_DATA'($urandom_range(0, 3));
        else if (sel == 5) wd = {$urandom, 16'($urandom)};
        else if (sel < 8) begin
          addr = osf_clr_req_addr;
          wd   = W_WR_DATA'($urandom_range(0, 1));
        end else if (sel == 8) begin
          addr = 16'h0123;
          wd   = 48'd1;
        end else begin
          wch = int'($urandom_range(8, 40));
          wd  = 48'd1;
        end
      end
      cycle(dv, ch, d, we, addr, wch, wd);
      checks++;
      if (dv_out !== exp_dv || chan_out !== hold_c || data_out !== hold_d) begin
        errors++;
        $display("FAIL random cyc=%0d dv_out=%0b/%0b chan_out=%0d/%0d data_out=%0d/%0d (got/exp)",
                 cyc, dv_out, exp_dv, chan_out, hold_c, data_out, hold_d);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    obs_pulses = 0;
    obs_first_c = 0; obs_first_d = 0; obs_last_c = 0; obs_last_d = 0;
    test_reset();
    test_ratio2();
    test_floor_passthrough();
    test_back_to_back();
    test_full_scale();
    test_clear();
    test_async_reset();
    test_random();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain outstanding=%0d (required 0)", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/osf_filter.md
Name: osf_filter

Overview:
- Per-channel oversampling averager directly upstream of the PID filter.
- Takes time-multiplexed ADC samples (dv/chan/data), accumulates 2^ratio samples per channel and emits one averaged sample per channel.
- The averaged sample feeds the PID stage's dv_in/chan_in/data_in.
- Ratio and clear requests are written through the shared wr_en/wr_addr/wr_chan/wr_data endpoint bus.

Parameters:
N_CHAN, 8, number of time-multiplexed channels
W_CHAN, 5, channel index width
W_DIN, 18, signed sample width (input and output)
W_OSF, 4, ratio field width
MAX_OSF, 8, largest legal log2 oversample ratio; larger writes saturate to MAX_OSF
W_WR_ADDR, 16, write address width
W_WR_CHAN, 16, write channel width
W_WR_DATA, 48, write data width

Ports:
clk_in  in  1  system clock
rst_in  in  1  reset; asynchronous, active-high
dv_in  in  1  input sample valid
chan_in  in  W_CHAN  input sample channel
data_in  in  W_DIN  signed input sample
wr_en  in  1  config write strobe
wr_addr  in  W_WR_ADDR  config address
wr_chan  in  W_WR_CHAN  target channel of the config write
wr_data  in  W_WR_DATA  config data
dv_out  out  1  averaged sample valid (single-cycle pulse)
chan_out  out  W_CHAN  averaged sample channel
data_out  out  W_DIN  signed averaged sample

Behaviour:
- Reset (async assert): dv_out=0, chan_out=0, data_out=0. All channel memories cleared: sum, count, ratio=0, clr_req. Pipe valids cleared.
- Per-channel state:
  - sum_mem: signed, W_DIN+MAX_OSF bits.
  - cnt_mem: MAX_OSF bits.
  - osf_mem: W_OSF bits.
  - clr_req: 1 bit.
- Accumulator cannot overflow: 2^MAX_OSF full-scale samples fit in W_DIN+MAX_OSF bits.
- Pipeline, 2 stages, latency 2 cycles from the dv_in that completes a window to dv_out.
  - P1: register dv, chan, data; fetch sum, count, ratio for chan_in.
  - P2: new_sum = sum + sign-extended data.
    - If count == 2^ratio-1: dv_out=1, data_out = new_sum >>> ratio (arithmetic, floor), chan_out=chan. Write back sum=0, count=0.
    - Else: dv_out=0 and write back new_sum, count+1.
    - chan_out/data_out hold their last value when dv_out=0.
- Hazard: same channel on consecutive dv_in cycles must see the P2 writeback. Forward the P2 result into P1; no sample may be lost or double-counted.
- Ratio 0 is passthrough: every valid sample is emitted 2 cycles later, unchanged.
- dv_in=0 cycles: no state change and no output.
- Config writes (wr_en=1, wr_chan < N_CHAN; others ignored):
  - osf_ratio_addr: osf_mem = min(wr_data[W_OSF-1:0], MAX_OSF). Also clears that channel's sum/count next cycle, so a partial window is discarded.
  - osf_clr_req_addr: sets clr_req if wr_data[0]=1.
- Clear processing (next clock edge after clr_req is set):
  - Zero that channel's sum and count; ratio is retained.
  - Squash any in-flight P1/P2 entry for that channel, so no dv_out for it.
  - Deassert clr_req.
- Clear vs sample, same cycle for the same channel: clear wins; the sample is dropped.
- Reset mid-window: the partial sum is discarded and no output is produced.

Decomposition:
- ep_map.vh (shared constants header) gains osf_ratio_addr and osf_clr_req_addr alongside the existing pid_* addresses.
- No sub-module; the channel memories and 2-stage pipe fit in one module (~200 lines).

Test Plan:
- Ratio=2 on ch3, dv_in samples 100,102,98,104 -> exactly one dv_out, chan_out=3, data_out=101, two cycles after the 4th sample; no earlier pulses.
- Ratio=1 on ch0, samples -3,-4 -> data_out=-4 (floor of -3.5); ratio=0 ch1 sample -131072 -> data_out=-131072 two cycles later.
- Ratio=2 on ch2 and ch5, back-to-back dv_in alternating ch2/ch5 (10,20,11,21,12,22,13,23), then 4 consecutive ch2 samples of 7 -> outputs ch2=11, ch5=21, then ch2=7.
- Ratio=8 on ch4, 256 samples of 131071 -> data_out=131071; 256 samples of -131072 -> data_out=-131072.
- Ratio=2 ch6, 2 samples of 50, clr_req write, then 4 samples of 8 -> single output 8; a clear issued while a completing sample is in P2 -> no dv_out.
- rst_in asserted asynchronously mid-window (between clock edges) -> dv_out/data_out immediately 0. After release, ratio defaults to 0 and the next sample passes through unchanged.
